// File: rtl/toy_fetch_redirect_arb_pkg.sv
// ----------------------------------------------------------------------------
// toy_pack
// Shared types for the fetch redirect arbiter: the redirect source enum that
// is also driven out on redirect_src, the arbiter FSM states, and the fetch
// address width.
// ----------------------------------------------------------------------------
package toy_pack;

   localparam int ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_TRAP = 2'd1,
      REDIR_BRU  = 2'd2,
      REDIR_BPU  = 2'd3
   } redir_src_e;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } redir_state_e;

endpackage : toy_pack

// File: rtl/toy_fetch_redirect_arb_outstanding_cnt.sv
// ----------------------------------------------------------------------------
// toy_fetch_outstanding_cnt
// Tracks fetch memory requests in flight and how many of them became stale
// because of a redirect, so that their responses can be discarded.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_req_fire_i   a fetch request was accepted this cycle
//   mem_rsp_vld_i    a fetch response returns this cycle
//   redirect_i       a redirect is issued this cycle (cancel_edge_en)
//   outstanding_o    requests in flight
//   full_o           outstanding_o == MAX_OUTSTANDING
//   rsp_drop_o       the current response belongs to a cancelled fetch
// ----------------------------------------------------------------------------
module toy_fetch_outstanding_cnt
   import toy_pack::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_req_fire_i,
   input  logic                 mem_rsp_vld_i,
   input  logic                 redirect_i,
   output logic [CNT_WIDTH-1:0] outstanding_o,
   output logic                 full_o,
   output logic                 rsp_drop_o
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] out_q, out_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;

   always_comb begin
      out_d = out_q;
      // Fire and response together leave the count unchanged; illegal
      // over/underflow saturates instead of wrapping.
      unique case ({mem_req_fire_i, mem_rsp_vld_i})
         2'b10:   if (out_q != MAX_CNT) out_d = out_q + ONE;
         2'b01:   if (out_q != '0)      out_d = out_q - ONE;
         default: out_d = out_q;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (redirect_i) begin
         // Everything in flight is stale except a response retiring right now.
         // A same-cycle fire is the redirected fetch itself, so it is not added.
         drop_d = (mem_rsp_vld_i && out_q != '0) ? out_q - ONE : out_q;
      end else if (mem_rsp_vld_i && drop_q != '0) begin
         drop_d = drop_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   assign outstanding_o = out_q;
   assign full_o        = (out_q == MAX_CNT);
   assign rsp_drop_o    = mem_rsp_vld_i && (drop_q != '0);

   a_no_rsp_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      mem_rsp_vld_i |-> (out_q != '0));

   a_no_fire_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      (mem_req_fire_i && !mem_rsp_vld_i) |-> (out_q != MAX_CNT));

endmodule : toy_fetch_outstanding_cnt

// File: rtl/toy_fetch_redirect_arb.sv
// ----------------------------------------------------------------------------
// toy_fetch_redirect_arb
// Arbitrates fetch redirects from trap, branch unit and branch predictor
// (fixed priority trap > bru > bpu), halts fetch after a trap until the trap
// handler releases it, and flags fetch responses made stale by a redirect.
//
// Build option: define TOY_FETCH_REDIRECT_BPU_EN to let the predictor port
// arbitrate; without it bpu_gnt is tied 0 and the bpu inputs are ignored.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   trap_req_vld/pc, trap_release_en  trap redirect and trap-done release
//   bru_req_vld/pc                 branch-mispredict redirect
//   bpu_req_vld/pc                 predictor redirect
//   mem_req_fire, mem_rsp_vld      fetch request accepted / response returned
//   trap_gnt, bru_gnt, bpu_gnt     one-cycle grant, same cycle as the request
//   cancel_edge_en, fetch_update_pc  redirect pulse and its target
//   redirect_src                   winning source
//   fetch_stall                    suppress new fetches (HALT or full)
//   rsp_drop                       discard the current response
//   outstanding                    requests in flight
// All outputs are forced to 0 while rst_n is low.
// ----------------------------------------------------------------------------
module toy_fetch_redirect_arb
   import toy_pack::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  trap_req_vld,
   input  logic [ADDR_WIDTH-1:0] trap_req_pc,
   input  logic                  trap_release_en,
   input  logic                  bru_req_vld,
   input  logic [ADDR_WIDTH-1:0] bru_req_pc,
   input  logic                  bpu_req_vld,
   input  logic [ADDR_WIDTH-1:0] bpu_req_pc,
   input  logic                  mem_req_fire,
   input  logic                  mem_rsp_vld,
   output logic                  trap_gnt,
   output logic                  bru_gnt,
   output logic                  bpu_gnt,
   output logic                  cancel_edge_en,
   output logic [ADDR_WIDTH-1:0] fetch_update_pc,
   output redir_src_e            redirect_src,
   output logic                  fetch_stall,
   output logic                  rsp_drop,
   output logic [CNT_WIDTH-1:0]  outstanding
);

   redir_state_e          state_q, state_d;
   redir_src_e            win;
   logic [ADDR_WIDTH-1:0] win_pc;
   logic                  bpu_vld;
   logic [ADDR_WIDTH-1:0] bpu_pc;
   logic                  cnt_full;

`ifdef TOY_FETCH_REDIRECT_BPU_EN
   assign bpu_vld = bpu_req_vld;
   assign bpu_pc  = bpu_req_pc;
`else
   logic bpu_unused;
   assign bpu_vld    = 1'b0;
   assign bpu_pc     = '0;
   assign bpu_unused = ^{bpu_req_vld, bpu_req_pc};
`endif

   // Arbitration and next state. Requests that lose are not remembered.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      win     = REDIR_NONE;
      win_pc  = '0;
      unique case (state_q)
         RUN: begin
            if (trap_req_vld) begin
               win     = REDIR_TRAP;
               win_pc  = trap_req_pc;
               state_d = HALT;
            end else if (bru_req_vld) begin
               win    = REDIR_BRU;
               win_pc = bru_req_pc;
            end else if (bpu_vld) begin
               win    = REDIR_BPU;
               win_pc = bpu_pc;
            end
         end
         HALT: begin
            if (trap_release_en) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: reset is in the sensitivity list, so it takes effect without a
   // clock edge; state registers use <= so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Combinational outputs are masked by rst_n so they read 0 during reset
   // even while requesters keep their valids high.
   assign trap_gnt        = rst_n && (win == REDIR_TRAP);
   assign bru_gnt         = rst_n && (win == REDIR_BRU);
   assign bpu_gnt         = rst_n && (win == REDIR_BPU);
   assign cancel_edge_en  = rst_n && (win != REDIR_NONE);
   assign fetch_update_pc = rst_n ? win_pc : '0;
   assign redirect_src    = rst_n ? win : REDIR_NONE;
   // A response in the same cycle frees a slot, so a full counter only stalls
   // when nothing retires.
   assign fetch_stall     = rst_n && ((state_q == HALT) || (cnt_full && !mem_rsp_vld));

   toy_fetch_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_cnt (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_fire_i (mem_req_fire),
      .mem_rsp_vld_i  (mem_rsp_vld),
      .redirect_i     (cancel_edge_en),
      .outstanding_o  (outstanding),
      .full_o         (cnt_full),
      .rsp_drop_o     (rsp_drop)
   );

endmodule : toy_fetch_redirect_arb

// File: doc/toy_fetch_redirect_arb.md
TOY_FETCH_REDIRECT_ARB -- requirements
Module: toy_fetch_redirect_arb

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: maximum fetch memory requests in flight.
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(MAX_OUTSTANDING+1): width of the outstanding and drop counters.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
trap_req_vld  in  1  trap redirect request
trap_req_pc  in  ADDR_WIDTH  trap target
trap_release_en  in  1  trap handling done; resume fetch
bru_req_vld  in  1  branch-mispredict redirect request
bru_req_pc  in  ADDR_WIDTH  mispredict target
bpu_req_vld  in  1  predictor redirect request
bpu_req_pc  in  ADDR_WIDTH  predicted target
mem_req_fire  in  1  fetch request accepted (vld&&rdy)
mem_rsp_vld  in  1  fetch response returned
trap_gnt / bru_gnt / bpu_gnt  out  1 each  one-cycle grant to the source
cancel_edge_en  out  1  redirect pulse to the fetch PC unit
fetch_update_pc  out  ADDR_WIDTH  redirect target, valid with cancel_edge_en
redirect_src  out  2  winning source (redir_src_e)
fetch_stall  out  1  suppress fetch_nxt_vld
rsp_drop  out  1  current response is stale; discard
outstanding  out  CNT_WIDTH  requests in flight

Function
REQ-004 SHALL implement FSM states RUN and HALT.
REQ-005 SHALL use fixed priority trap > bru > bpu; at most one grant per cycle.
REQ-006 In RUN, a winning request SHALL produce, in the same cycle (combinational): its grant=1, cancel_edge_en=1, fetch_update_pc=its PC, and redirect_src set.
REQ-007 A trap grant SHALL move RUN->HALT at the next edge.
REQ-008 In HALT, all bru/bpu/trap requests SHALL be ignored with no grant and cancel_edge_en=0, and fetch_stall SHALL be 1.
REQ-009 trap_release_en in HALT SHALL return the FSM to RUN at the next edge; in RUN it SHALL have no effect.
REQ-010 An ungranted request SHALL NOT be latched; sources re-assert.
REQ-011 Counter outstanding SHALL do +1 on mem_req_fire, -1 on mem_rsp_vld, and hold when both occur in the same cycle.
REQ-012 fetch_stall SHALL be 1 when outstanding==MAX_OUTSTANDING and mem_rsp_vld=0.
REQ-013 On cancel_edge_en, drop_cnt SHALL load outstanding minus mem_rsp_vld. A same-cycle mem_req_fire is the redirected fetch and SHALL NOT be counted as stale.
REQ-014 rsp_drop SHALL equal mem_rsp_vld && drop_cnt!=0. Otherwise, a response SHALL decrement drop_cnt.
REQ-015 A redirect arriving while drop_cnt>0 SHALL reload drop_cnt per REQ-013, superseding the old value.
REQ-016 mem_rsp_vld with outstanding==0, or mem_req_fire at MAX_OUTSTANDING, SHALL be flagged by an assertion, with the counter saturating.

Reset
REQ-017 On rst_n low, the block SHALL asynchronously set state=RUN, outstanding=0, and drop_cnt=0.
REQ-018 While rst_n is low, all outputs SHALL be 0, including fetch_update_pc=0 and redirect_src=REDIR_NONE.
REQ-019 Reset asserted in HALT or with requests in flight SHALL discard all state; no response tracking survives reset.

Configuration
REQ-020 With TOY_FETCH_REDIRECT_BPU_EN defined, the bpu port SHALL arbitrate per REQ-005.
REQ-021 Without TOY_FETCH_REDIRECT_BPU_EN, bpu_gnt SHALL be tied 0, bpu inputs ignored, and arbitration SHALL be trap > bru only.

Structure
REQ-022 toy_pack SHALL hold the enum redir_src_e {REDIR_NONE, REDIR_TRAP, REDIR_BRU, REDIR_BPU} and the enum redir_state_e {RUN, HALT}.
REQ-023 Outstanding/drop counting SHALL be the sub-module toy_fetch_outstanding_cnt; arbitration and the FSM stay in the top level.

Verification
REQ-024 The bench SHALL cover: bru_req_vld=1, pc=0x8000_0100 in RUN -> same cycle bru_gnt=1, cancel_edge_en=1, fetch_update_pc=0x8000_0100, redirect_src=REDIR_BRU.
REQ-025 The bench SHALL cover: trap 0x8000_0004, bru and bpu all asserted together -> only trap_gnt=1; next cycle HALT, fetch_stall=1, bru ignored for 5 cycles; trap_release_en -> RUN next cycle, fetch_stall=0.
REQ-026 The bench SHALL cover: 3 fires outstanding, then a bru redirect together with mem_req_fire -> drop_cnt=3; next 3 responses rsp_drop=1; 4th response rsp_drop=0, outstanding ends 0.
REQ-027 The bench SHALL cover: redirect with a same-cycle response, outstanding=2 -> drop_cnt=1; redirect again while drop_cnt=1 with outstanding=3 -> drop_cnt=3.
REQ-028 The bench SHALL cover: 4 fires (MAX_OUTSTANDING=4) -> fetch_stall=1; mem_rsp_vld -> fetch_stall=0 in the same cycle.
REQ-029 The bench SHALL cover: rst_n pulsed low in HALT with outstanding=2 -> state=RUN, outstanding=0, all outputs 0; and the macro undefined -> bpu_req_vld alone gives no grant.
